// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared sizing constants and types for the 16x4 FIFO controller.
//   Pointers and the occupancy count are ADDR_W+1 bits wide. The extra MSB
//   of a pointer is its wrap bit. The count needs that bit to represent DEPTH.
//   Optional feature macro used by the controller: FIFO_CTRL_ERR_FLAGS_EN.
package fifo_pkg;

    localparam int DATA_W   = 4;
    localparam int ADDR_W   = 4;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 14;
    localparam int AE_LEVEL = 2;

    typedef logic [ADDR_W:0] ptr_t;
    typedef logic [ADDR_W:0] cnt_t;

    // Memory address carried by a wrapping pointer (drop the wrap bit).
    function automatic logic [ADDR_W-1:0] ptr_addr(input ptr_t p);
        return p[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_ctrl_16x4_ptr.sv
// fifo_ptr
//   Wrapping ADDR_W+1 bit pointer register. It counts 0..2*DEPTH-1 and then
//   returns to 0.
// Ports
//   clk    in   clock, posedge
//   rst_n  in   synchronous active-low reset, clears pointer to 0
//   inc    in   advance pointer by one at this edge
//   ptr    out  current pointer value (registered)
module fifo_ptr
    import fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    output ptr_t ptr
);

    ptr_t r_ptr;

    // The natural ADDR_W+1 bit overflow gives the 2*DEPTH-1 -> 0 wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= r_ptr + ptr_t'(1);
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_16x4.sv
// fifo_ctrl_16x4
//   Synchronous FIFO controller placed in front of a 16x4 dual-port memory.
//   It turns push/pop requests into memory write/read port activity. It also
//   tracks occupancy and the full/empty/almost flags.
//   Optional macro FIFO_CTRL_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
// Ports
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   push, push_data   write request and its data
//   pop               read request
//   rd_data, rd_valid read word, valid in the one-cycle strobe after an accepted pop
//   full, empty, almost_full, almost_empty, count   occupancy status (registered)
//   mem_wr_en/addr/data   memory write port (wr_en1/address_1/data_1)
//   mem_rd_en/addr        memory read port (rd_en2/address_2)
//   mem_rd_data           memory read data (data_2)
//   overflow, underflow   sticky error flags (only with FIFO_CTRL_ERR_FLAGS_EN)
//
// Request semantics: a push is taken in any cycle where push=1 and full=0.
// A pop is taken in any cycle where pop=1 and empty=0. The flags act as the
// "ready" side and are registered, so acceptance is purely combinational from
// state. Requests made when not ready are dropped, not held. An accepted pop
// returns its word on rd_data with rd_valid=1 exactly one cycle later.
module fifo_ctrl_16x4
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    logic w_push_acc;
    logic w_pop_acc;
    ptr_t w_wr_ptr;
    ptr_t w_rd_ptr;
    cnt_t w_count_nxt;

    cnt_t r_count;
    logic r_rd_valid;
    logic r_full;
    logic r_empty;
    logic r_almost_full;
    logic r_almost_empty;

    // Collision between write and read addresses cannot occur. A pop needs
    // ~empty and a push needs ~full, so both pointers never hit the same
    // live slot in the same cycle.
    assign w_push_acc = push & ~r_full;
    assign w_pop_acc  = pop & ~r_empty;

    fifo_ptr u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push_acc),
        .ptr   (w_wr_ptr)
    );

    fifo_ptr u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_pop_acc),
        .ptr   (w_rd_ptr)
    );

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop_acc})
            2'b10:   w_count_nxt = r_count + cnt_t'(1);
            2'b01:   w_count_nxt = r_count - cnt_t'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are computed from the next count so they line up with count itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_rd_valid     <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_count        <= w_count_nxt;
            r_rd_valid     <= w_pop_acc;
            r_full         <= (w_count_nxt == cnt_t'(DEPTH));
            r_empty        <= (w_count_nxt == cnt_t'(0));
            r_almost_full  <= (w_count_nxt >= cnt_t'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= cnt_t'(AE_LEVEL));
        end
    end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow | (push & r_full);
            r_underflow <= r_underflow | (pop & r_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    assign mem_wr_en   = w_push_acc;
    assign mem_wr_addr = ptr_addr(w_wr_ptr);
    assign mem_wr_data = push_data;

    // Read enable is kept high during the rd_valid cycle because the memory
    // gates its data output with rd_en2. The memory output is passed straight
    // through and not re-registered here.
    assign mem_rd_en   = w_pop_acc | r_rd_valid;
    assign mem_rd_addr = ptr_addr(w_rd_ptr);
    assign rd_data     = mem_rd_data;
    assign rd_valid    = r_rd_valid;

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;

endmodule

// File: tb/tb_fifo_ctrl_16x4.sv
// tb_fifo_ctrl_16x4
//   Directed bench for fifo_ctrl_16x4 with a behavioural memory_16x4 stand-in.
//   A queue-based FIFO model is compared with the DUT on every negedge.
//   Directed steps add literal expectations at key points.
module tb_fifo_ctrl_16x4;

    logic       clk;
    logic       rst_n;
    logic       push;
    logic [3:0] push_data;
    logic       pop;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       mem_wr_en;
    logic [3:0] mem_wr_addr;
    logic [3:0] mem_wr_data;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [3:0] mem_rd_data;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    fifo_ctrl_16x4 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (push),
        .push_data    (push_data),
        .pop          (pop),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data)
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // ---------------- memory stand-in (registered read) ----------------
    logic [3:0] tb_mem [16];
    logic [3:0] mem_q = 4'h0;

    always @(posedge clk) begin
        if (mem_wr_en) tb_mem[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) mem_q <= tb_mem[mem_rd_addr];
    end
    assign mem_rd_data = mem_q;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] exp_q[$];
    logic       m_ready = 1'b0;
    logic       m_rv    = 1'b0;
    logic [3:0] m_word  = 4'h0;
    int         m_wr_n  = 0;
    int         m_rd_n  = 0;
    logic       m_ovf   = 1'b0;
    logic       m_udf   = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rv    = 1'b0;
            m_wr_n  = 0;
            m_rd_n  = 0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_ready = 1'b1;
        end else if (m_ready) begin
            automatic int  sz = exp_q.size();
            automatic logic pa = push && (sz < 16);
            automatic logic pp = pop && (sz > 0);
            if (push && sz == 16) m_ovf = 1'b1;
            if (pop && sz == 0) m_udf = 1'b1;
            m_rv = pp;
            if (pp) begin
                m_word = exp_q.pop_front();
                m_rd_n++;
            end
            if (pa) begin
                exp_q.push_back(push_data);
                m_wr_n++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ready) begin
            automatic int sz = exp_q.size();
            chk("count", count, sz);
            chk("full", full, sz == 16);
            chk("empty", empty, sz == 0);
            chk("almost_full", almost_full, sz >= 14);
            chk("almost_empty", almost_empty, sz <= 2);
            chk("rd_valid", rd_valid, m_rv);
            if (m_rv) chk("rd_data", rd_data, m_word);
            chk("mem_wr_en", mem_wr_en, push && sz < 16);
            chk("mem_wr_addr", mem_wr_addr, m_wr_n % 16);
            chk("mem_wr_data", mem_wr_data, push_data);
            chk("mem_rd_en", mem_rd_en, (pop && sz > 0) || m_rv);
            chk("mem_rd_addr", mem_rd_addr, m_rd_n % 16);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_udf);
`endif
        end
    end

    // ---------------- driver ----------------
    // Drive inputs, then advance past the next posedge (+2 so outputs settle).
    task automatic cycle(input logic p, input logic [3:0] d, input logic q);
        push      = p;
        push_data = d;
        pop       = q;
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_seq [16];
    logic [3:0] got [16];
    int         n_got;

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        push_data = 4'h0;
        pop       = 1'b0;
        for (int i = 0; i < 16; i++) exp_seq[i] = 4'((i + 1) % 16);

        // reset
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst_n = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);

        // fill 16: 0x1..0xF,0x0
        for (int i = 0; i < 16; i++) begin
            cycle(1, exp_seq[i], 0);
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1) >= 14);
        end
        chk("fill_full", full, 1);

        // 17th push ignored
        push = 1'b1;
        push_data = 4'hA;
        #1;
        chk("ovf_push_wr_en", mem_wr_en, 0);
        cycle(1, 4'hA, 0);
        chk("ovf_push_count", count, 16);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("overflow_set", overflow, 1);
`endif

        // 16 back-to-back pops
        n_got = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(0, 0, i < 16);
            if (rd_valid && n_got < 16) begin
                got[n_got] = rd_data;
                n_got++;
            end
        end
        chk("pop_words", n_got, 16);
        for (int i = 0; i < 16; i++) chk("pop_seq", got[i], exp_seq[i]);
        chk("drain_empty", empty, 1);

        // 17th pop on empty
        cycle(0, 0, 1);
        chk("udf_rd_valid", rd_valid, 0);
        cycle(0, 0, 0);
        chk("udf_rd_valid2", rd_valid, 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("underflow_set", underflow, 1);
        cycle(0, 0, 0);
        chk("underflow_sticky", underflow, 1);
`endif

        // fill 8, then 40 cycles of simultaneous push+pop (pointers wrap past 31)
        for (int i = 0; i < 8; i++) cycle(1, 4'((i * 3 + 5) % 16), 0);
        chk("half_count", count, 8);
        for (int i = 0; i < 40; i++) begin
            cycle(1, 4'((i * 7 + 2) % 16), 1);
            chk("stream_count", count, 8);
        end

        // reset on the cycle after a pop cancels the in-flight rd_valid
        cycle(0, 0, 1);
        chk("pre_rst_rd_valid", rd_valid, 1);
        rst_n = 1'b0;
        cycle(0, 0, 0);
        rst_n = 1'b1;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
        chk("rst_underflow", underflow, 0);
        chk("rst_overflow", overflow, 0);
`endif
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
